oq_header_inserter: RTL and testbench
=====================================

Name: oq_header_inserter

Overview:
- Store-and-forward block that builds the IOQ module header for each packet and places it ahead of the packet data.
- Sits upstream of the output queues. It is the writer for the word the output-queue header parser consumes (ctrl == IOQ_STAGE_NUM, carrying dst port, byte length and word length).
- Buffers each packet while counting its length, then emits the header word followed by the buffered packet.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width; one ctrl bit per data byte.
- IOQ_STAGE_NUM, `IO_QUEUE_STAGE_NUM, ctrl value of the emitted header word.
- NUM_OUTPUT_QUEUES, 8, width of the one-hot dst field.
- MAX_PKT, 2048, byte bound used for field widths.
- PKT_BYTE_CNT_WIDTH, log2(MAX_PKT), width of the byte length field.
- PKT_WORD_CNT_WIDTH, log2(MAX_PKT/CTRL_WIDTH), width of the word length field.
- DATA_FIFO_DEPTH_BITS, 9, log2 depth of the packet data FIFO; the FIFO must hold at least 2^PKT_WORD_CNT_WIDTH words.
- LEN_FIFO_DEPTH_BITS, 2, log2 depth of the per-packet length/dst FIFO.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  packet data.
- in_ctrl  in  CTRL_WIDTH  0 on body words; nonzero marks EOP and encodes the valid bytes.
- in_wr  in  1  input word valid; only legal while in_rdy=1.
- in_rdy  out  1  block can accept a word.
- in_dst_oq  in  NUM_OUTPUT_QUEUES  one-hot destination; sampled on the first word of each packet.
- out_data  out  DATA_WIDTH  output data.
- out_ctrl  out  CTRL_WIDTH  output ctrl.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream can accept a word this cycle.

Behaviour:
- Data FIFO and length FIFO are fallthrough_small_fifo instances.
- Data FIFO entry width is CTRL_WIDTH+DATA_WIDTH.
- Length FIFO entry is {word_len, byte_len, dst_oq}.
- in_rdy = !reset && !data_fifo.nearly_full && !len_fifo.nearly_full.

Input FSM:
- States IN_SOP and IN_BODY; reset state IN_SOP.
- Every in_wr word is written to the data FIFO unchanged.
- IN_SOP, on in_wr:
  - latch in_dst_oq;
  - word_cnt=1;
  - if in_ctrl==0, go to IN_BODY; otherwise the packet is a single word, so finish it here.
- IN_BODY, on in_wr: word_cnt+1; if in_ctrl!=0, finish and go to IN_SOP.
- Finish:
  - write the length FIFO in the same cycle as the EOP word;
  - byte_len = (word_cnt-1)*CTRL_WIDTH + valid bytes of the last word.
- Valid bytes of the last word, for CTRL_WIDTH=8: ctrl 0x01=8, 0x02=7, 0x04=6, 0x08=5, 0x10=4, 0x20=3, 0x40=2, 0x80=1.
  - General rule: a one-hot bit at position k gives CTRL_WIDTH-k valid bytes.
  - Any other ctrl value gives CTRL_WIDTH valid bytes.
- Supported packet length is 1..MAX_PKT-CTRL_WIDTH bytes, i.e. at most 2^PKT_WORD_CNT_WIDTH-1 words. Longer packets are a protocol error: simulation must $display an error and $stop.

Output FSM:
- States OUT_IDLE and OUT_PKT; reset state OUT_IDLE.
- out_wr, out_data and out_ctrl are combinational from the FSM and the FIFO heads; out_wr=0 while reset is asserted.
- OUT_IDLE: when the length FIFO is non-empty and out_rdy=1:
  - out_wr=1, out_ctrl=IOQ_STAGE_NUM;
  - out_data: the head's one-hot dst at `IOQ_DST_PORT_POS, byte_len at `IOQ_BYTE_LEN_POS, word_len at `IOQ_WORD_LEN_POS; all other bits 0;
  - go to OUT_PKT.
- OUT_PKT: when the data FIFO is non-empty and out_rdy=1:
  - out_wr=1, out_data/out_ctrl = FIFO head; pop the data FIFO.
  - If the popped ctrl!=0: pop the length FIFO and go to OUT_IDLE.
- Never assert out_wr while out_rdy=0. Words are never dropped or duplicated across out_rdy stalls.
- Latency: the header may appear the cycle after the EOP word is written. The first data word follows the header with no bubble when out_rdy stays 1.

Boundaries and simultaneous events:
- The input and output sides operate concurrently. Packet N+1 may be written while packet N drains.
- A length-FIFO push and pop in the same cycle are both honoured.
- The header is never emitted before its packet's EOP has been written (strict store-and-forward).
- Reset asserted mid-operation:
  - both FIFOs flushed, both FSMs return to idle, the partial packet is discarded;
  - the first packet after reset is emitted correctly.

Test Plan:
- 60-byte packet, 8 words, last ctrl 0x10, dst 0x04 -> header ctrl=IOQ_STAGE_NUM, dst=0x04, byte_len=60, word_len=8; then the 8 words unchanged.
- Single word, ctrl 0x80, dst 0x01 -> byte_len=1, word_len=1; exactly 2 output words.
- 2040-byte packet, 255 words, last ctrl 0x01 -> byte_len=2040, word_len=255; no error.
- Three back-to-back 64-byte packets with out_rdy=0 until all are written -> in_rdy deasserts only at FIFO nearly-full; after out_rdy=1, three header+8-word sequences in order.
- out_rdy toggled randomly on a 100-byte packet -> 14 output words exactly, no duplicates, out_wr never high while out_rdy=0.
- Reset during word 3 of a packet -> no output for that packet; the next 60-byte packet yields a correct header and data.

Source files
------------

// File: rtl/oq_header_inserter.sv
// Store-and-forward framer: buffers each packet while measuring it, then emits
// an IOQ module header (dst port, byte length, word length) ahead of the data.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 'hff
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 0
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 32
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             nearly_full_o,
  output logic             empty_o
);
  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      full, do_wr, do_rd;

  // Head is read combinationally so a word is visible the cycle after its write.
  assign dout_o        = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign full          = count_q[MAX_DEPTH_BITS];
  assign nearly_full_o = (count_q >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  assign do_rd         = rd_en_i && !empty_o;
  assign do_wr         = wr_en_i && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(do_wr);
    rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(do_rd);
    count_d  = count_q + (MAX_DEPTH_BITS+1)'(do_wr) - (MAX_DEPTH_BITS+1)'(do_rd);
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module oq_header_inserter #(
  parameter int DATA_WIDTH           = 64,
  parameter int CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter int IOQ_STAGE_NUM        = `IO_QUEUE_STAGE_NUM,
  parameter int NUM_OUTPUT_QUEUES    = 8,
  parameter int MAX_PKT              = 2048,
  parameter int PKT_BYTE_CNT_WIDTH   = $clog2(MAX_PKT),
  parameter int PKT_WORD_CNT_WIDTH   = $clog2(MAX_PKT / CTRL_WIDTH),
  parameter int DATA_FIFO_DEPTH_BITS = 9,
  parameter int LEN_FIFO_DEPTH_BITS  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  input  logic [NUM_OUTPUT_QUEUES-1:0] in_dst_oq,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy
);
  localparam int BYTE_W = PKT_BYTE_CNT_WIDTH;
  localparam int WORD_W = PKT_WORD_CNT_WIDTH;
  localparam int NOQ    = NUM_OUTPUT_QUEUES;
  localparam int LEN_W  = WORD_W + BYTE_W + NOQ;
  localparam int DF_W   = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic { IN_SOP,   IN_BODY } in_state_e;
  typedef enum logic { OUT_IDLE, OUT_PKT } out_state_e;

  in_state_e         in_state_q, in_state_d;
  out_state_e        out_state_q, out_state_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d, eop_words;
  logic [NOQ-1:0]    dst_q, dst_d, eop_dst;
  logic [BYTE_W-1:0] eop_bytes;

  logic              df_wr, df_rd, df_nf, df_empty;
  logic [DF_W-1:0]   df_dout;
  logic              lf_wr, lf_rd, lf_nf, lf_empty;
  logic [LEN_W-1:0]  lf_din, lf_dout;
  logic [WORD_W-1:0] lf_words;
  logic [BYTE_W-1:0] lf_bytes;
  logic [NOQ-1:0]    lf_dst;
  logic [DATA_WIDTH-1:0] hdr;

  // One-hot bit k of the EOP ctrl means CTRL_WIDTH-k valid bytes; anything else is a full word.
  function automatic int unsigned valid_bytes(input logic [CTRL_WIDTH-1:0] c);
    valid_bytes = 32'(CTRL_WIDTH);
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      if (c == (CTRL_WIDTH'(1) << k)) valid_bytes = 32'(CTRL_WIDTH - k);
    end
  endfunction

  assign in_rdy = !reset && !df_nf && !lf_nf;
  assign df_wr  = in_wr && !reset;

  fallthrough_small_fifo #(.WIDTH(DF_W), .MAX_DEPTH_BITS(DATA_FIFO_DEPTH_BITS)) u_data_fifo (
    .clk_i(clk), .rst_i(reset), .din_i({in_ctrl, in_data}), .wr_en_i(df_wr),
    .rd_en_i(df_rd), .dout_o(df_dout), .nearly_full_o(df_nf), .empty_o(df_empty)
  );

  fallthrough_small_fifo #(.WIDTH(LEN_W), .MAX_DEPTH_BITS(LEN_FIFO_DEPTH_BITS)) u_len_fifo (
    .clk_i(clk), .rst_i(reset), .din_i(lf_din), .wr_en_i(lf_wr),
    .rd_en_i(lf_rd), .dout_o(lf_dout), .nearly_full_o(lf_nf), .empty_o(lf_empty)
  );

  // Input side: count words and push {word_len, byte_len, dst} on the EOP word.
  always_comb begin
    in_state_d = in_state_q;
    word_cnt_d = word_cnt_q;
    dst_d      = dst_q;
    lf_wr      = 1'b0;
    eop_words  = word_cnt_q + WORD_W'(1);
    eop_dst    = dst_q;
    if (in_state_q == IN_SOP) begin
      eop_words = WORD_W'(1);
      eop_dst   = in_dst_oq;
    end
    eop_bytes = BYTE_W'((32'(eop_words) - 32'd1) * 32'(CTRL_WIDTH) + valid_bytes(in_ctrl));
    lf_din    = {eop_words, eop_bytes, eop_dst};
    if (in_wr && !reset) begin
      word_cnt_d = eop_words;
      dst_d      = eop_dst;
      if (in_ctrl != '0) begin
        lf_wr      = 1'b1;
        in_state_d = IN_SOP;
      end else begin
        in_state_d = IN_BODY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q <= IN_SOP;
      word_cnt_q <= '0;
    end else begin
      in_state_q <= in_state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    dst_q <= dst_d;
  end

  // A word beyond the word-length field range would silently wrap the count.
  always_ff @(posedge clk) begin
    if (!reset && in_wr && in_state_q == IN_BODY) begin
      assert (word_cnt_q != '1) else begin
        $error("oq_header_inserter: packet longer than %0d words", (2 ** WORD_W) - 1);
        $stop;
      end
    end
  end

  assign {lf_words, lf_bytes, lf_dst} = lf_dout;

  always_comb begin
    hdr = '0;
    hdr[`IOQ_DST_PORT_POS +: NOQ]   = lf_dst;
    hdr[`IOQ_BYTE_LEN_POS +: BYTE_W] = lf_bytes;
    hdr[`IOQ_WORD_LEN_POS +: WORD_W] = lf_words;
  end

  // Output side: header from the length FIFO head, then data until the EOP word.
  always_comb begin
    out_state_d = out_state_q;
    out_wr      = 1'b0;
    out_data    = '0;
    out_ctrl    = '0;
    df_rd       = 1'b0;
    lf_rd       = 1'b0;
    if (!reset && out_rdy) begin
      case (out_state_q)
        OUT_IDLE: begin
          if (!lf_empty) begin
            out_wr      = 1'b1;
            out_ctrl    = CTRL_WIDTH'(IOQ_STAGE_NUM);
            out_data    = hdr;
            out_state_d = OUT_PKT;
          end
        end
        OUT_PKT: begin
          if (!df_empty) begin
            out_wr              = 1'b1;
            {out_ctrl, out_data} = df_dout;
            df_rd               = 1'b1;
            if (df_dout[DF_W-1 -: CTRL_WIDTH] != '0) begin
              lf_rd       = 1'b1;
              out_state_d = OUT_IDLE;
            end
          end
        end
        default: out_state_d = OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_state_q <= OUT_IDLE;
    else       out_state_q <= out_state_d;
  end
endmodule

// File: tb/tb_oq_header_inserter.sv
// Directed/randomized bench for oq_header_inserter with a queue-based packet model.
module tb_oq_header_inserter;
  localparam int         DST_POS  = 48;
  localparam int         WORD_POS = 32;
  localparam int         BYTE_POS = 0;
  localparam logic [7:0] STAGE    = 8'hff;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [7:0]  in_dst_oq;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;

  always #5 clk = ~clk;

  oq_header_inserter dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .in_dst_oq(in_dst_oq), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy)
  );

  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  int errors = 0;
  int checks = 0;
  int wr_while_stalled = 0;
  int in_stalls = 0;

  always @(negedge clk) begin
    if (out_wr) begin
      got_q.push_back({out_ctrl, out_data});
      if (!out_rdy) wr_while_stalled++;
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input logic [7:0] dst);
    int waited = 0;
    while (!in_rdy && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_rdy) begin
      $display("FAIL in_rdy_timeout: observed in_rdy=0 for %0d cycles, required 1", waited);
      $fatal(1, "input side stuck");
    end
    if (waited != 0) in_stalls++;
    in_wr = 1'b1; in_data = d; in_ctrl = c; in_dst_oq = dst;
    @(posedge clk); #1;
    in_wr = 1'b0; in_ctrl = 8'h00; in_dst_oq = 8'h00;
  endtask

  // Model: header from the packet's byte length, then the words unchanged.
  task automatic send_pkt(input int len, input logic [7:0] dst);
    int          words = (len + 7) / 8;
    int          last_bytes = len - 8 * (words - 1);
    logic [63:0] h;
    logic [63:0] d;
    logic [7:0]  c;
    h = (64'(dst) << DST_POS) | (64'(words) << WORD_POS) | (64'(len) << BYTE_POS);
    exp_q.push_back({STAGE, h});
    for (int i = 0; i < words; i++) begin
      c = (i == words - 1) ? 8'(1 << (8 - last_bytes)) : 8'h00;
      d = {$urandom, $urandom};
      exp_q.push_back({c, d});
      drive_word(d, c, (i == 0) ? dst : 8'($urandom));
    end
  endtask

  task automatic drain(input string tag, input bit random_rdy);
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 5000) begin
      out_rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] onehot_dst();
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  initial begin
    int          bubbles;
    logic [71:0] hdr0;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; in_dst_oq = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_rdy", 72'(in_rdy), 72'(0));
    chk("reset_out_wr", 72'(out_wr), 72'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_rdy", 72'(in_rdy), 72'(1));
    chk("idle_out_wr", 72'(out_wr), 72'(0));

    // 60-byte packet: nothing before EOP, then header + 8 words with no bubble
    send_pkt(60, 8'h04);
    chk("t1_no_early_output", 72'(got_q.size()), 72'(0));
    bubbles = 0;
    repeat (9) begin
      @(negedge clk);
      if (!out_wr) bubbles++;
    end
    @(posedge clk); #1;
    chk("t1_no_bubble", 72'(bubbles), 72'(0));
    hdr0 = (got_q.size() > 0) ? got_q[0] : '0;
    chk("t1_hdr_ctrl", 72'(hdr0[71:64]), 72'(8'hff));
    chk("t1_hdr_dst", 72'(hdr0[DST_POS +: 8]), 72'(8'h04));
    chk("t1_hdr_byte_len", 72'(hdr0[BYTE_POS +: 11]), 72'(60));
    chk("t1_hdr_word_len", 72'(hdr0[WORD_POS +: 8]), 72'(8));
    drain("t1", 1'b0);

    // single-word packet
    send_pkt(1, 8'h01);
    drain("t2", 1'b0);

    // maximum supported packet: 255 words, 2040 bytes
    send_pkt(2040, onehot_dst());
    drain("t3", 1'b0);

    // three packets buffered with the output stalled
    out_rdy = 1'b0;
    in_stalls = 0;
    for (int p = 0; p < 3; p++) send_pkt(64, onehot_dst());
    chk("t4_in_rdy_never_dropped", 72'(in_stalls), 72'(0));
    chk("t4_in_rdy_nearly_full", 72'(in_rdy), 72'(0));
    chk("t4_no_output_stalled", 72'(got_q.size()), 72'(0));
    drain("t4", 1'b0);
    chk("t4_in_rdy_after_drain", 72'(in_rdy), 72'(1));

    // 100-byte packet drained under random back-pressure
    out_rdy = 1'b0;
    send_pkt(100, onehot_dst());
    chk("t5_expected_len", 72'(exp_q.size()), 72'(14));
    drain("t5", 1'b1);
    chk("t5_no_wr_while_stalled", 72'(wr_while_stalled), 72'(0));

    // reset in the middle of a packet discards it
    out_rdy = 1'b1;
    drive_word({$urandom, $urandom}, 8'h00, 8'h02);
    drive_word({$urandom, $urandom}, 8'h00, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_in_rdy", 72'(in_rdy), 72'(0));
    chk("t6_reset_out_wr", 72'(out_wr), 72'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_partial_dropped", 72'(got_q.size()), 72'(0));
    send_pkt(60, 8'h20);
    drain("t6", 1'b0);

    // a few random-length packets with random back-pressure
    for (int p = 0; p < 4; p++) send_pkt(int'($urandom_range(1, 200)), onehot_dst());
    drain("t7", 1'b1);
    chk("final_no_wr_while_stalled", 72'(wr_while_stalled), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
